// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared defaults, state encoding and width helper for the MAC datapath
package mac_pkg;

    localparam int PROD_W_DEF = 8;
    localparam int COUNT_DEF  = 4;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } acc_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/term_counter.sv
// rtl/term_counter.sv - modulo-COUNT term counter with sync clear and async reset
module term_counter #(
    parameter int COUNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clear,
    output logic [3:0] count,
    output logic       last
);

    assign last = (count == 4'(COUNT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 4'd0;
        end else if (clear) begin
            count <= 4'd0;
        end else if (inc) begin
            count <= last ? 4'd0 : count + 4'd1;
        end
    end

endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums COUNT multiplier products into one registered result
// with valid/ready on both sides and a zero-bubble handoff from HOLD.
module product_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int COUNT  = COUNT_DEF,
    parameter int ACC_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic              clear,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [3:0]        term_count
);

    if (COUNT < 1 || COUNT > 16) begin : g_bad_count
        $error("product_accumulator: COUNT must be within 1..16");
    end
    if (ACC_W < PROD_W + clog2(COUNT)) begin : g_bad_width
        $error("product_accumulator: ACC_W too narrow for COUNT products");
    end

    acc_state_t       state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic             prod_hs;
    logic             last;

    assign prod_ext = ACC_W'(prod_in);
    assign sum      = acc + prod_ext;

    // In HOLD the input side only moves when the result leaves in the same cycle.
    assign prod_ready = !rst && !clear && ((state == ST_ACCUM) || acc_ready);
    assign prod_hs    = prod_valid && prod_ready;

    term_counter #(
        .COUNT(COUNT)
    ) u_term_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (prod_hs),
        .clear(clear),
        .count(term_count),
        .last (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_ACCUM;
            acc       <= '0;
            acc_out   <= '0;
            acc_valid <= 1'b0;
        end else if (clear) begin
            state     <= ST_ACCUM;
            acc       <= '0;
            acc_valid <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (prod_hs) begin
                        if (last) begin
                            acc_out   <= sum;
                            acc_valid <= 1'b1;
                            acc       <= '0;
                            state     <= ST_HOLD;
                        end else begin
                            acc <= sum;
                        end
                    end
                end
                ST_HOLD: begin
                    if (acc_ready) begin
                        if (prod_valid && (COUNT == 1)) begin
                            acc_out <= prod_ext;
                        end else if (prod_valid) begin
                            acc       <= prod_ext;
                            acc_valid <= 1'b0;
                            state     <= ST_ACCUM;
                        end else begin
                            acc_valid <= 1'b0;
                            state     <= ST_ACCUM;
                        end
                    end
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - scoreboard bench for product_accumulator (COUNT=4 and COUNT=1)
module tb_product_accumulator;

    logic       clk;
    logic       rst;
    logic [7:0] prod_in;
    logic       prod_valid;
    logic       prod_ready;
    logic       clear;
    logic [9:0] acc_out;
    logic       acc_valid;
    logic       acc_ready;
    logic [3:0] term_count;

    logic [7:0] prod_in1;
    logic       prod_valid1;
    logic       prod_ready1;
    logic       clear1;
    logic [9:0] acc_out1;
    logic       acc_valid1;
    logic       acc_ready1;
    logic [3:0] term_count1;

    int checks;
    int failures;
    logic [9:0] exp_q[$];
    logic [9:0] exp1_q[$];

    product_accumulator #(.PROD_W(8), .COUNT(4), .ACC_W(10)) dut (
        .clk(clk), .rst(rst), .prod_in(prod_in), .prod_valid(prod_valid),
        .prod_ready(prod_ready), .clear(clear), .acc_out(acc_out),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .term_count(term_count)
    );

    product_accumulator #(.PROD_W(8), .COUNT(1), .ACC_W(10)) dut1 (
        .clk(clk), .rst(rst), .prod_in(prod_in1), .prod_valid(prod_valid1),
        .prod_ready(prod_ready1), .clear(clear1), .acc_out(acc_out1),
        .acc_valid(acc_valid1), .acc_ready(acc_ready1), .term_count(term_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    // Scoreboard monitors: pop one expected result per output handshake.
    always @(negedge clk) begin
        if (!rst && acc_valid && acc_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", int'(acc_out), -1);
            end else begin
                check("acc_out", int'(acc_out), int'(exp_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && acc_valid1 && acc_ready1) begin
            if (exp1_q.size() == 0) begin
                check("unexpected_result_c1", int'(acc_out1), -1);
            end else begin
                check("acc_out_c1", int'(acc_out1), int'(exp1_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] p);
        bit done;
        done       = 1'b0;
        prod_in    = p;
        prod_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (prod_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic idle();
        prod_valid = 1'b0;
        prod_in    = 8'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        prod_in = 8'd0; prod_valid = 1'b0; clear = 1'b0; acc_ready = 1'b1;
        prod_in1 = 8'd0; prod_valid1 = 1'b0; clear1 = 1'b0; acc_ready1 = 1'b1;
        step();
        step();
        check("reset_acc_valid", int'(acc_valid), 0);
        check("reset_acc_out", int'(acc_out), 0);
        check("reset_term_count", int'(term_count), 0);
        check("reset_prod_ready", int'(prod_ready), 0);
        rst = 1'b0;
        #1;
        check("post_reset_prod_ready", int'(prod_ready), 1);
        step();

        // Basic sum: 63 + 225 + 0 + 1 = 289, valid for a single cycle.
        exp_q.push_back(10'd289);
        send(8'd63); send(8'd225); send(8'd0); send(8'd1);
        idle();
        check("basic_valid_rise", int'(acc_valid), 1);
        step();
        check("basic_valid_one_cycle", int'(acc_valid), 0);

        // Max value: 4 x 225 = 900, no wrap.
        exp_q.push_back(10'd900);
        for (int i = 0; i < 4; i++) send(8'd225);
        idle();
        step();

        // Backpressure and zero-bubble handoff.
        acc_ready = 1'b0;
        exp_q.push_back(10'd100);
        send(8'd10); send(8'd20); send(8'd30); send(8'd40);
        prod_valid = 1'b1;
        prod_in    = 8'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_prod_ready", int'(prod_ready), 0);
            check("bp_acc_out", int'(acc_out), 100);
            check("bp_term_count", int'(term_count), 0);
            check("bp_acc_valid", int'(acc_valid), 1);
            @(posedge clk);
            #1;
        end
        acc_ready = 1'b1;
        @(negedge clk);
        check("handoff_prod_ready", int'(prod_ready), 1);
        step();
        check("handoff_term_count", int'(term_count), 1);
        check("handoff_acc_valid", int'(acc_valid), 0);
        exp_q.push_back(10'd13);
        send(8'd1); send(8'd2); send(8'd3);
        idle();
        step();

        // Clear mid-sum: 99 is refused, sum restarts.
        send(8'd50); send(8'd60);
        clear = 1'b1; prod_valid = 1'b1; prod_in = 8'd99;
        @(negedge clk);
        check("clear_prod_ready", int'(prod_ready), 0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        idle();
        check("clear_term_count", int'(term_count), 0);
        check("clear_acc_valid", int'(acc_valid), 0);
        exp_q.push_back(10'd10);
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        idle();
        step();

        // Clear while holding drops the result; acc_out keeps its stale value.
        acc_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'd5);
        idle();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("hold_clear_acc_valid", int'(acc_valid), 0);
        check("hold_clear_acc_out", int'(acc_out), 20);
        check("hold_clear_term_count", int'(term_count), 0);

        // Async reset between edges while holding 289.
        send(8'd63); send(8'd225); send(8'd0); send(8'd1);
        idle();
        check("pre_rst_acc_out", int'(acc_out), 289);
        check("pre_rst_acc_valid", int'(acc_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_acc_valid", int'(acc_valid), 0);
        check("async_rst_acc_out", int'(acc_out), 0);
        check("async_rst_term_count", int'(term_count), 0);
        #2;
        rst = 1'b0;
        step();
        check("after_rst_prod_ready", int'(prod_ready), 1);
        acc_ready = 1'b1;

        // COUNT=1: each product is its own result, valid stays high.
        exp1_q.push_back(10'd5);
        exp1_q.push_back(10'd6);
        exp1_q.push_back(10'd7);
        prod_valid1 = 1'b1;
        prod_in1 = 8'd5;
        step();
        check("c1_valid_5", int'(acc_valid1), 1);
        prod_in1 = 8'd6;
        step();
        check("c1_valid_6", int'(acc_valid1), 1);
        prod_in1 = 8'd7;
        step();
        check("c1_valid_7", int'(acc_valid1), 1);
        prod_valid1 = 1'b0;
        step();
        check("c1_valid_drop", int'(acc_valid1), 0);
        step();

        check("scoreboard_drained", exp_q.size(), 0);
        check("scoreboard_drained_c1", exp1_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
Sequential stage directly downstream of the team's combinational 4x4 array multiplier. It consumes the multiplier's 8-bit unsigned product under a valid/ready handshake and sums COUNT consecutive products into one dot-product term. Each completed sum is presented on a registered output with its own valid/ready handshake. It is the first clocked stage after the multiplier in the small MAC datapath.

Parameters:
PROD_W, 8, width of the incoming unsigned product (multiplier out[7:0]).
COUNT, 4, number of products summed per result; legal range 1..16.
ACC_W, 10, accumulator/result width. Must be >= PROD_W + clog2(COUNT). Elaboration fails if violated, so no overflow is possible.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
prod_in  input  PROD_W  product from the multiplier; unsigned.
prod_valid  input  1  prod_in holds a product to accumulate.
prod_ready  output  1  block accepts prod_in this cycle (combinational).
clear  input  1  synchronous abort: discards the partial sum and any held result.
acc_out  output  ACC_W  completed sum; registered.
acc_valid  output  1  acc_out is valid; registered.
acc_ready  input  1  consumer takes acc_out this cycle.
term_count  output  4  number of products accumulated in the current partial sum; registered.

Behaviour:
- Reset (async, any time, including mid-sum or while holding): state=ACCUM, acc=0, term_count=0, acc_out=0, acc_valid=0. prod_ready goes high once rst deasserts.
- A handshake occurs when valid&ready are both high at a rising clk edge. Products are zero-extended to ACC_W before adding.
- State ACCUM:
  - prod_ready=1, acc_valid=0.
  - On a product handshake with term_count < COUNT-1: acc += prod_in and term_count++.
  - On a handshake with term_count == COUNT-1: acc_out <= acc + prod_in, acc_valid <= 1, acc <= 0, term_count <= 0, go to HOLD.
- State HOLD:
  - acc_valid=1 and acc_out is stable until it is accepted.
  - prod_ready = acc_ready, a combinational pass-through that allows a zero-bubble handoff.
  - If acc_ready=1 and prod_valid=0: acc_valid <= 0, go to ACCUM.
  - If acc_ready=1 and prod_valid=1: the result is consumed and the new product is accepted as term 1 (acc <= prod_in, term_count <= 1, go to ACCUM).
  - Exception for COUNT=1: the new product becomes the next result immediately (acc_out <= prod_in, stay in HOLD, acc_valid stays 1).
  - If acc_ready=0: hold everything, prod_ready=0.
- Latency: acc_valid rises on the edge of the COUNT-th product handshake. The result is visible the cycle after that handshake.
- Sustained throughput: one product per cycle, with no bubble between results as long as acc_ready=1.
- clear has priority over all other activity. In that cycle prod_ready=0 and no product is accepted. Next state is ACCUM with acc=0, term_count=0, acc_valid=0. A held result is dropped and acc_out keeps its stale value.
- Whenever acc_valid=0, acc_out is don't-care for consumers, but the RTL must not change it except when loading a new result.
- prod_in and prod_valid are ignored whenever prod_ready=0.

Decomposition:
- Shared package mac_pkg holds:
  - PROD_W default (8).
  - Default COUNT (4).
  - State encoding localparams ST_ACCUM=1'b0 and ST_HOLD=1'b1.
  - The clog2 function used for the ACC_W legality check.
- One sub-module is natural: term_counter, a modulo-COUNT up-counter with inc, sync clear and async rst. Its outputs are count and a last flag (count==COUNT-1).
- The state machine and adder remain in product_accumulator.

Test Plan:
- Basic sum, COUNT=4: feed products 63 (9x7), 225 (15x15), 0, 1 back-to-back with acc_ready=1. Required: acc_out=289 (0x121) with acc_valid high for exactly one cycle, the cycle after the 4th handshake.
- Max value: feed four products of 225. Required: acc_out=900 with no wrap, fitting ACC_W=10.
- Backpressure: complete a sum of 10+20+30+40, hold acc_ready=0 for 5 cycles while prod_valid=1. Required: prod_ready=0, acc_out=100 stable, term_count=0. Raising acc_ready with prod_in=7 gives the handoff, with term_count=1 on the next cycle.
- Clear mid-sum: accept 50 and 60, then assert clear with prod_valid=1 and prod_in=99. Required: 99 is not accepted and term_count=0. The next four products 1, 2, 3, 4 give acc_out=10.
- Async reset: assert rst between clock edges while in HOLD with acc_out=289. Required: acc_valid, acc_out and term_count go to 0 immediately, without waiting for a clock edge.
- COUNT=1 variant: stream 5, 6, 7 with acc_ready=1. Required: acc_out=5, 6, 7 on consecutive cycles with acc_valid continuously 1.
